// File: rtl/arc4_key_search_if.sv
// Bus bundle for arc4_key_search.
// Carries the host start/result handshake, the arc4 en/rdy/key handshake and the pt_mem
// read port.
//   slave  : the key-search controller
//   master : the surrounding top (host, arc4 core, pt_mem read mux)
// Optional macro KEY_SEARCH_ABORT_EN adds the host-driven abort request.
interface arc4_key_search_if #(
   parameter int unsigned KEY_WIDTH  = 24,
   parameter int unsigned ADDR_WIDTH = 8
);
   // host side
   logic                  en;
   logic                  rdy;
   logic [KEY_WIDTH-1:0]  key_lo;
   logic [KEY_WIDTH-1:0]  key_hi;
   logic                  done;
   logic                  found;
   logic [KEY_WIDTH-1:0]  key;
`ifdef KEY_SEARCH_ABORT_EN
   logic                  abort;
`endif
   // arc4 side
   logic                  a4_en;
   logic                  a4_rdy;
   logic [KEY_WIDTH-1:0]  a4_key;
   // pt_mem read port
   logic                  pt_owner;
   logic [ADDR_WIDTH-1:0] pt_addr;
   logic [7:0]            pt_rddata;

`ifdef KEY_SEARCH_ABORT_EN
   modport slave (
      input  en, key_lo, key_hi, abort, a4_rdy, pt_rddata,
      output rdy, done, found, key, a4_en, a4_key, pt_owner, pt_addr
   );
   modport master (
      output en, key_lo, key_hi, abort, a4_rdy, pt_rddata,
      input  rdy, done, found, key, a4_en, a4_key, pt_owner, pt_addr
   );
`else
   modport slave (
      input  en, key_lo, key_hi, a4_rdy, pt_rddata,
      output rdy, done, found, key, a4_en, a4_key, pt_owner, pt_addr
   );
   modport master (
      output en, key_lo, key_hi, a4_rdy, pt_rddata,
      input  rdy, done, found, key, a4_en, a4_key, pt_owner, pt_addr
   );
`endif
endinterface

// File: rtl/arc4_key_search.sv
// Brute-force ARC4 key-search controller.
// Steps a candidate key from key_lo to key_hi (inclusive, no wrap), runs arc4 for each one,
// then scans the length-prefixed plaintext in pt_mem and stops at the first key whose
// plaintext bytes all lie in [LO_CHAR, HI_CHAR].
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : arc4_key_search_if.slave
//          en/rdy/key_lo/key_hi  start handshake and inclusive candidate range
//          done/found/key        result, held until the next accepted start
//          a4_en/a4_rdy/a4_key   arc4 handshake, a4_key stable while arc4 is busy
//          pt_owner/pt_addr/pt_rddata  pt_mem read port (1-cycle latency)
// Optional macro KEY_SEARCH_ABORT_EN adds bus.abort: finish any arc4 run, then report
// found=0.
module arc4_key_search #(
   parameter int unsigned KEY_WIDTH  = 24,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter logic [7:0]  LO_CHAR    = 8'h20,
   parameter logic [7:0]  HI_CHAR    = 8'h7E
) (
   input logic              clk,
   input logic              rst,
   arc4_key_search_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle, StLaunch, StBusy1, StBusy, StRdLen, StLen, StScan, StFin
   } state_e;

   state_e                state_q, state_d;
   logic [KEY_WIDTH-1:0]  cur_q, cur_d;
   logic [KEY_WIDTH-1:0]  hi_q, hi_d;
   logic [KEY_WIDTH-1:0]  key_q, key_d;
   logic [ADDR_WIDTH-1:0] len_q, len_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  done_q, done_d;
   logic                  found_q, found_d;
   logic                  aborting;
   logic                  byte_ok;
   logic                  cand_pass;
   logic                  cand_fail;

`ifdef KEY_SEARCH_ABORT_EN
   logic abort_q, abort_d;
   assign aborting = bus.abort | abort_q;
`else
   assign aborting = 1'b0;
`endif

   assign byte_ok = (bus.pt_rddata >= LO_CHAR) && (bus.pt_rddata <= HI_CHAR);

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      hi_d      = hi_q;
      key_d     = key_q;
      len_d     = len_q;
      idx_d     = idx_q;
      addr_d    = addr_q;
      done_d    = done_q;
      found_d   = found_q;
      cand_pass = 1'b0;
      cand_fail = 1'b0;
`ifdef KEY_SEARCH_ABORT_EN
      abort_d   = abort_q | bus.abort;
`endif
      unique case (state_q)
         StIdle: begin
`ifdef KEY_SEARCH_ABORT_EN
            abort_d = 1'b0;
`endif
            if (bus.en) begin
               cur_d   = bus.key_lo;
               hi_d    = bus.key_hi;
               done_d  = 1'b0;
               found_d = 1'b0;
               key_d   = '0;
               state_d = (bus.key_lo > bus.key_hi) ? StFin : StLaunch;
            end
         end
         StLaunch: begin
            if (aborting) state_d = StFin;
            else if (bus.a4_rdy) state_d = StBusy1;
         end
         // arc4 still shows rdy in the cycle right after accepting en
         StBusy1: state_d = StBusy;
         StBusy: begin
            if (bus.a4_rdy) begin
               addr_d  = '0;
               state_d = aborting ? StFin : StRdLen;
            end
         end
         StRdLen: begin
            addr_d  = ADDR_WIDTH'(1);
            state_d = StLen;
         end
         StLen: begin
            // address 1 is already in flight; issue 2 next only if the message needs it
            if (bus.pt_rddata == 8'd0) begin
               cand_pass = 1'b1;
            end else begin
               len_d   = ADDR_WIDTH'(bus.pt_rddata);
               idx_d   = ADDR_WIDTH'(1);
               addr_d  = (bus.pt_rddata > 8'd1) ? ADDR_WIDTH'(2) : '0;
               state_d = StScan;
            end
         end
         StScan: begin
            if (!byte_ok) begin
               cand_fail = 1'b1;
            end else if (idx_q == len_q) begin
               cand_pass = 1'b1;
            end else begin
               idx_d  = idx_q + 1'b1;
               addr_d = (addr_q < len_q) ? addr_q + 1'b1 : '0;
            end
         end
         StFin: begin
            done_d  = 1'b1;
            addr_d  = '0;
            state_d = StIdle;
`ifdef KEY_SEARCH_ABORT_EN
            abort_d = 1'b0;
`endif
         end
         default: state_d = StIdle;
      endcase

      if (cand_pass) begin
         key_d   = cur_q;
         found_d = 1'b1;
         addr_d  = '0;
         state_d = StFin;
      end else if (cand_fail) begin
         addr_d = '0;
         if (cur_q == hi_q) begin
            state_d = StFin;
         end else begin
            cur_d   = cur_q + 1'b1;
            state_d = StLaunch;
         end
      end

      // abort during the scan discards the candidate regardless of its outcome
      if (aborting && (state_q inside {StRdLen, StLen, StScan})) begin
         key_d   = '0;
         found_d = 1'b0;
         addr_d  = '0;
         state_d = StFin;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cur_q   <= '0;
         hi_q    <= '0;
         key_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         done_q  <= 1'b0;
         found_q <= 1'b0;
`ifdef KEY_SEARCH_ABORT_EN
         abort_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         hi_q    <= hi_d;
         key_q   <= key_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
         found_q <= found_d;
`ifdef KEY_SEARCH_ABORT_EN
         abort_q <= abort_d;
`endif
      end
   end

   // combinational outputs are forced low while rst is held
   assign bus.rdy      = (state_q == StIdle) && !rst;
   assign bus.a4_en    = (state_q == StLaunch) && bus.a4_rdy && !aborting && !rst;
   assign bus.pt_owner = (state_q inside {StRdLen, StLen, StScan}) && !rst;
   assign bus.pt_addr  = addr_q;
   assign bus.a4_key   = cur_q;
   assign bus.done     = done_q;
   assign bus.found    = found_q;
   assign bus.key      = key_q;

endmodule

// File: tb/tb_arc4_key_search.sv
module tb_arc4_key_search;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   arc4_key_search_if #(.KEY_WIDTH(24), .ADDR_WIDTH(8)) bus();

   arc4_key_search #(
      .KEY_WIDTH(24), .ADDR_WIDTH(8), .LO_CHAR(8'h20), .HI_CHAR(8'h7E)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic        found;
      logic [23:0] key;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // ---------------- arc4 + pt_mem model ----------------
   // mode 0: key 7 -> printable "len 4" message, others -> 41 1F 42
   // mode 1: every key -> 41 1F 42 (fails at second byte)
   // mode 2: every key -> length 0 (passes immediately)
   int         mode     = 0;
   logic       a4_rdy_m = 1'b1;
   int         busy_cnt = 0;
   logic [7:0] pt_mem[256];
   logic [7:0] rd_q;

   function automatic logic [7:0] pt_byte(input int m, input logic [23:0] k, input int i);
      if (m == 2) return (i == 0) ? 8'd0 : 8'h7F;
      if (m == 0 && k == 24'd7) begin
         case (i)
            0: return 8'd4;
            1: return 8'h20;
            2: return 8'h41;
            3: return 8'h7E;
            4: return 8'h5A;
            default: return 8'hFF;
         endcase
      end
      case (i)
         0: return 8'd3;
         1: return 8'h41;
         2: return 8'h1F;
         3: return 8'h42;
         default: return 8'hFF;
      endcase
   endfunction

   assign bus.a4_rdy    = a4_rdy_m;
   assign bus.pt_rddata = rd_q;

   always @(posedge clk) begin
      rd_q <= pt_mem[bus.pt_addr];
      if (bus.a4_en) begin
         busy_cnt <= 5;
         a4_rdy_m <= 1'b0;
         for (int i = 0; i < 8; i++) pt_mem[i] <= pt_byte(mode, bus.a4_key, i);
      end else if (busy_cnt > 1) begin
         busy_cnt <= busy_cnt - 1;
      end else if (busy_cnt == 1) begin
         busy_cnt <= 0;
         a4_rdy_m <= 1'b1;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   int          pulses    = 0;
   int          addr3     = 0;
   int          owner_cyc = 0;
   int          en_viol   = 0;
   logic [23:0] last_key  = '0;
   logic        done_prev = 1'b0;

   always @(negedge clk) begin
      if (bus.a4_en) begin
         pulses   <= pulses + 1;
         last_key <= bus.a4_key;
         if (!bus.a4_rdy) en_viol <= en_viol + 1;
      end
      if (bus.pt_owner) owner_cyc <= owner_cyc + 1;
      if (bus.pt_owner && bus.pt_addr == 8'd3) addr3 <= addr3 + 1;
      done_prev <= bus.done;
      if (bus.done && !done_prev) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("sb_found", bus.found, mon_e.found);
            check("sb_key", bus.key, mon_e.key);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic start(input logic [23:0] lo, input logic [23:0] hi);
      int n = 0;
      while (!bus.rdy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("start_rdy", bus.rdy, 1);
      bus.en     = 1'b1;
      bus.key_lo = lo;
      bus.key_hi = hi;
      @(posedge clk); #1;
      bus.en = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!bus.done && cyc < budget);
      check({name, "_done"}, bus.done, 1);
      @(posedge clk); #1;
   endtask

   task automatic push_exp(input logic f, input logic [23:0] k);
      exp_t e;
      e.found = f;
      e.key   = k;
      exp_q.push_back(e);
   endtask

   int p0, a0, o0, n;

   initial begin
      bus.en     = 1'b0;
      bus.key_lo = '0;
      bus.key_hi = '0;
`ifdef KEY_SEARCH_ABORT_EN
      bus.abort  = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_rdy", bus.rdy, 0);
      check("rst_a4_en", bus.a4_en, 0);
      check("rst_pt_owner", bus.pt_owner, 0);
      check("rst_done", bus.done, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_rdy", bus.rdy, 1);
      check("idle_found", bus.found, 0);
      check("idle_key", bus.key, 0);
      check("idle_a4_key", bus.a4_key, 0);
      check("idle_pt_addr", bus.pt_addr, 0);
      @(posedge clk); #1;

      // empty range: no launch, done within 3 cycles
      push_exp(1'b0, 24'd0);
      p0 = pulses;
      start(24'd5, 24'd3);
      wait_done("inv_range", 3);
      check("inv_range_pulses", pulses - p0, 0);

      // key 7 is the only pass in 0..15; a stray en while busy is ignored
      mode = 0;
      push_exp(1'b1, 24'd7);
      p0 = pulses;
      start(24'd0, 24'd15);
      bus.en     = 1'b1;
      bus.key_lo = 24'h100;
      bus.key_hi = 24'h200;
      @(posedge clk); #1;
      bus.en = 1'b0;
      wait_done("key7", 1000);
      check("key7_pulses", pulses - p0, 8);
      check("key7_last_a4_key", last_key, 24'd7);

      // top of key space: no wrap after all-ones
      mode = 1;
      push_exp(1'b0, 24'd0);
      p0 = pulses;
      start(24'hFFFFFE, 24'hFFFFFF);
      wait_done("top", 500);
      check("top_pulses", pulses - p0, 2);
      check("top_last_a4_key", last_key, 24'hFFFFFF);

      // early fail on 8'h1F: addr 3 issued once, 4 owner cycles
      push_exp(1'b0, 24'd0);
      p0 = pulses;
      a0 = addr3;
      o0 = owner_cyc;
      start(24'd9, 24'd9);
      wait_done("early_fail", 200);
      check("early_fail_pulses", pulses - p0, 1);
      check("early_fail_addr3", addr3 - a0, 1);
      check("early_fail_owner_cyc", owner_cyc - o0, 4);

      // zero-length message passes on the first candidate
      mode = 2;
      push_exp(1'b1, 24'h10);
      p0 = pulses;
      o0 = owner_cyc;
      start(24'h10, 24'h20);
      wait_done("len0", 200);
      check("len0_pulses", pulses - p0, 1);
      check("len0_owner_cyc", owner_cyc - o0, 2);

`ifdef KEY_SEARCH_ABORT_EN
      // abort pulsed in A4_BUSY
      mode = 1;
      push_exp(1'b0, 24'd0);
      p0 = pulses;
      start(24'h50, 24'h60);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.a4_en && n < 50);
      check("abort_saw_launch", bus.a4_en, 1);
      @(posedge clk); #1;
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      wait_done("abort", 200);
      check("abort_pulses", pulses - p0, 1);
`endif

      // reset for one cycle in the middle of SCAN
      mode = 1;
      start(24'h30, 24'h40);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.pt_owner && bus.pt_addr == 8'd2) && n < 100);
      check("midscan_reached", bus.pt_owner, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midscan_rdy", bus.rdy, 1);
      check("midscan_done", bus.done, 0);
      check("midscan_found", bus.found, 0);
      check("midscan_a4_en", bus.a4_en, 0);
      check("midscan_pt_owner", bus.pt_owner, 0);
      @(posedge clk); #1;

      // normal search after the reset
      mode = 0;
      push_exp(1'b1, 24'd7);
      p0 = pulses;
      start(24'd6, 24'd8);
      wait_done("post_rst", 300);
      check("post_rst_pulses", pulses - p0, 2);

      repeat (3) @(posedge clk);
      #1;
      check("sb_empty", exp_q.size(), 0);
      check("a4_en_while_not_rdy", en_viol, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/arc4_key_search.md
Name: arc4_key_search

Overview:
- Parametrised brute-force key-search controller for the ARC4 decryption datapath.
- Iterates a candidate key over an inclusive range and drives the existing arc4 core through its en/rdy handshake for each candidate.
- After each decryption, scans the length-prefixed plaintext in pt_mem and stops at the first key whose plaintext is entirely within a printable byte range.
- Sits between the board-level top and arc4; the top muxes the pt_mem read port using pt_owner.

Parameters:
- KEY_WIDTH, 24: candidate key width in bits; also the width of a4_key.
- ADDR_WIDTH, 8: pt_mem address width; maximum message length is 2**ADDR_WIDTH-1.
- LO_CHAR, 8'h20: lowest acceptable plaintext byte, inclusive.
- HI_CHAR, 8'h7E: highest acceptable plaintext byte, inclusive.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  start request; accepted only in a cycle where rdy=1
- rdy  out  1  idle and ready to accept en
- key_lo  in  KEY_WIDTH  first candidate, sampled on accept
- key_hi  in  KEY_WIDTH  last candidate (inclusive), sampled on accept
- done  out  1  search finished; held until next accept
- found  out  1  valid when done=1; 1 means key holds a passing candidate
- key  out  KEY_WIDTH  passing key; 0 when found=0
- a4_en  out  1  one-cycle start pulse to arc4
- a4_rdy  in  1  arc4 ready
- a4_key  out  KEY_WIDTH  candidate key presented to arc4; stable while arc4 is busy
- pt_owner  out  1  1 = this block drives the pt_mem read address
- pt_addr  out  ADDR_WIDTH  pt_mem read address
- pt_rddata  in  8  pt_mem read data; 1-cycle read latency

Behaviour:
- Reset values: rdy=0, done=0, found=0, key=0, a4_en=0, a4_key=0, pt_owner=0, pt_addr=0.
- Reset mid-search abandons all work. The first cycle after rst falls is IDLE with rdy=1.
- IDLE: rdy=1. On en=1, latch key_lo/key_hi, set cur=key_lo, clear done/found, set rdy=0 in the next cycle.
  - If key_lo > key_hi: go to FIN with found=0 and never launch arc4.
  - Otherwise go to LAUNCH.
- LAUNCH: a4_key=cur. Wait for a4_rdy=1, then assert a4_en for exactly one cycle and go to A4_BUSY.
- A4_BUSY: ignore a4_rdy in the first cycle after the pulse (arc4 drops rdy the cycle after accepting en). From the second cycle, a4_rdy=1 goes to RD_LEN.
- RD_LEN: pt_owner=1, pt_addr=0. One cycle later, latch len=pt_rddata.
  - len=0: candidate passes.
  - Otherwise go to SCAN.
- SCAN: pipelined, one address per cycle, pt_addr=1..len; each byte checked one cycle after its address is issued.
  - Byte outside [LO_CHAR,HI_CHAR]: fail immediately and discard the in-flight read.
  - All bytes pass: candidate passes.
  - An all-pass scan costs len+1 cycles after RD_LEN.
- Pass: key=cur, found=1, go to FIN.
- Fail:
  - cur==key_hi: go to FIN with found=0, key=0.
  - Otherwise cur=cur+1 and go to LAUNCH.
  - No wrap: key_hi = all-ones terminates after testing all-ones.
- FIN: done=1, pt_owner=0, then IDLE (rdy=1). done/found/key are held until the next accepted en.
- en while rdy=0 is ignored.
- pt_owner=0 in every state except RD_LEN/SCAN.
- a4_en is never asserted while a4_rdy=0.

Optional Feature:
- Macro KEY_SEARCH_ABORT_EN.
- Defined: adds input abort (1 bit).
  - abort=1 in any busy state makes the block finish the current arc4 operation if one is in progress (wait for a4_rdy), then go to FIN with found=0, key=0.
  - abort in IDLE has no effect.
  - abort and en in the same IDLE cycle: en wins.
- Undefined: no abort port; a search runs to a pass or to key_hi.

Test Plan:
- Reset in the middle of SCAN for 1 cycle -> next cycle: rdy=1, done=0, found=0, a4_en=0, pt_owner=0.
- key_lo=5, key_hi=3 -> done=1, found=0 within 3 cycles of accept; a4_en never pulses.
- Model arc4 yields printable plaintext only for key 24'h000007; range 0..15 -> exactly 8 a4_en pulses, key=24'h000007, found=1.
- No key passes in range 24'hFFFFFE..24'hFFFFFF -> 2 launches, done=1, found=0, no wrap to 0.
- pt[0]=3, pt[1..3]=8'h41,8'h1F,8'h42 -> fail detected when the byte 8'h1F is checked; address 3 is issued at most once; next key launched. With pt[0]=0 -> immediate pass.
- KEY_SEARCH_ABORT_EN: abort pulsed in A4_BUSY -> a4_en not pulsed again; done=1, found=0 the cycle after FIN is entered.
